// File: rtl/gt_share_arb.sv
// Round-robin arbiter/sequencer sharing a single 2-bit greater-than comparator
// among NREQ requesters; one compare every three cycles at most.

module gt (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       y
);
    assign y = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
endmodule

// state | meaning
// IDLE  | waiting for any req; arbitrates from rr_ptr and captures operands
// CMP   | captured operands on the shared comparator; result registered on exit
// ACK   | ack[gnt_id] and ans valid for this single cycle
module gt_share_arb #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   a_in,
    input  logic [2*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]     ack,
    output logic                ans,
    output logic [ID_W-1:0]     gnt_id,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_nxt, gnt_nxt, winner, scan_id;
    logic [1:0]      op_a, op_b, opa_nxt, opb_nxt, a_sel, b_sel;
    logic [NREQ-1:0] ack_nxt;
    logic            found, gt_y, ans_nxt, busy_nxt;

    gt u_gt (
        .a (op_a),
        .b (op_b),
        .y (gt_y)
    );

    // first set req bit at or after rr_ptr, wrapping at NREQ
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        scan_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(rr_ptr) + k >= NREQ) begin
                scan_id = ID_W'(int'(rr_ptr) + k - NREQ);
            end else begin
                scan_id = ID_W'(int'(rr_ptr) + k);
            end
            if (!found && req[scan_id]) begin
                found  = 1'b1;
                winner = scan_id;
            end
        end
    end

    always_comb begin
        a_sel = 2'b00;
        b_sel = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                a_sel = a_in[2*i +: 2];
                b_sel = b_in[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        gnt_nxt   = gnt_id;
        opa_nxt   = op_a;
        opb_nxt   = op_b;
        ack_nxt   = '0;
        ans_nxt   = 1'b0;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = CMP;
                    opa_nxt   = a_sel;
                    opb_nxt   = b_sel;
                    gnt_nxt   = winner;
                    rr_nxt    = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
                    busy_nxt  = 1'b1;
                end
            end
            CMP: begin
                state_nxt       = ACK;
                ans_nxt         = gt_y;
                ack_nxt[gnt_id] = 1'b1;
            end
            ACK: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            op_a   <= 2'b00;
            op_b   <= 2'b00;
            ack    <= '0;
            ans    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            gnt_id <= gnt_nxt;
            op_a   <= opa_nxt;
            op_b   <= opb_nxt;
            ack    <= ack_nxt;
            ans    <= ans_nxt;
            busy   <= busy_nxt;
        end
    end
endmodule
